// File: rtl/hash_result_scan_if.sv
// Bundle of the scan request, memory read port and result signals for
// hash_result_scan. The slave side is the scanner; the master side is the
// environment that issues start and services the memory reads.
interface hash_result_scan_if #(
   parameter int NUM_NONCES = 16,
   parameter int ADDR_W     = 16
);
   localparam int IDX_W = $clog2(NUM_NONCES);
   localparam int CNT_W = IDX_W + 1;

   logic              start;
   logic [ADDR_W-1:0] hash_out_addr;
   logic [31:0]       target;

   logic              mem_clk;
   logic              mem_we;
   logic [ADDR_W-1:0] memory_addr;
   logic [31:0]       memory_read_data;

   logic              busy;
   logic              done;
   logic              found;
   logic [CNT_W-1:0]  match_count;
   logic [IDX_W-1:0]  best_nonce;
   logic [31:0]       best_hash;

   modport master (
      output start, hash_out_addr, target, memory_read_data,
      input  mem_clk, mem_we, memory_addr, busy, done,
      input  found, match_count, best_nonce, best_hash
   );

   modport slave (
      input  start, hash_out_addr, target, memory_read_data,
      output mem_clk, mem_we, memory_addr, busy, done,
      output found, match_count, best_nonce, best_hash
   );
endinterface

// File: rtl/hash_result_scan.sv
// Scans NUM_NONCES consecutive 32-bit hash words from a memory with a
// two-cycle read latency, counting words strictly below a target and
// tracking the minimum word and its nonce index. NUM_NONCES must be >= 2.
module hash_result_scan #(
   parameter int NUM_NONCES = 16,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   hash_result_scan_if.slave bus
);
   localparam int DATA_W = 32;
   localparam int IDX_W  = $clog2(NUM_NONCES);
   localparam int CNT_W  = IDX_W + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_NONCES - 1);
   localparam logic [IDX_W-1:0]  ONE_IDX   = IDX_W'(1);
   localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
   localparam logic [DATA_W-1:0] HASH_INIT = {DATA_W{1'b1}};

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [IDX_W-1:0]  iss_cnt;
   logic [IDX_W-1:0]  cap_cnt;
   logic [DATA_W-1:0] target_q;

   // Read-pipeline valid: p0 marks an address issued this cycle, p1 marks
   // that memory_read_data carries that word at the next edge.
   logic              vld_p0;
   logic              vld_p1;

   logic              found_q;
   logic [CNT_W-1:0]  match_q;
   logic [IDX_W-1:0]  best_nonce_q;
   logic [DATA_W-1:0] best_hash_q;

   logic              start_acc;
   logic [DATA_W-1:0] word;

   // Count of matches can reach NUM_NONCES; never let it wrap past that.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_W'(NUM_NONCES)) ? v : v + CNT_W'(1);
   endfunction

   // Nonce 0 always seeds the minimum; later words must be strictly lower so
   // ties stay with the earlier nonce.
   function automatic logic is_better(input logic [DATA_W-1:0] w,
                                      input logic [DATA_W-1:0] best,
                                      input logic [IDX_W-1:0]  idx);
      return (idx == '0) || (w < best);
   endfunction

   assign start_acc = (state == S_IDLE) && bus.start;
   assign word      = bus.memory_read_data;

   // Stage p0: FSM, address issue and read-valid pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         iss_cnt <= '0;
         cap_cnt <= '0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         vld_p0 <= 1'b0;
         if (vld_p1) begin
            cap_cnt <= cap_cnt + ONE_IDX;
         end
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  addr_q  <= bus.hash_out_addr;
                  iss_cnt <= '0;
                  cap_cnt <= '0;
                  vld_p0  <= 1'b1;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (iss_cnt == LAST_IDX) begin
                  state <= S_DRAIN;
               end else begin
                  addr_q  <= addr_q + ONE_ADDR;
                  iss_cnt <= iss_cnt + ONE_IDX;
                  vld_p0  <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (vld_p1 && (cap_cnt == LAST_IDX)) begin
                  state <= S_FINISH;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Threshold is held for the whole run so a changing input cannot skew it
   always_ff @(posedge clk) begin
      if (start_acc) begin
         target_q <= bus.target;
      end
   end

   // Stage p2: fold each returned word into the running results
   always_ff @(posedge clk) begin
      if (reset || start_acc) begin
         found_q      <= 1'b0;
         match_q      <= '0;
         best_nonce_q <= '0;
         best_hash_q  <= HASH_INIT;
      end else if (vld_p1) begin
         if (word < target_q) begin
            found_q <= 1'b1;
            match_q <= sat_inc(match_q);
         end
         if (is_better(word, best_hash_q, cap_cnt)) begin
            best_hash_q  <= word;
            best_nonce_q <= cap_cnt;
         end
      end
   end

   assign bus.mem_clk     = clk;
   assign bus.mem_we      = 1'b0;
   assign bus.memory_addr = addr_q;
   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = (state == S_FINISH);
   assign bus.found       = found_q;
   assign bus.match_count = match_q;
   assign bus.best_nonce  = best_nonce_q;
   assign bus.best_hash   = best_hash_q;
endmodule
